// File: rtl/cve2_register_file_mp.sv
// Multi-port flip-flop register file for cve2 with a per-register
// write-pending scoreboard used for RAW stalls in multi-issue decode.
module cve2_register_file_mp #(
    parameter bit                   RV32E       = 1'b0,
    parameter int unsigned          DataWidth   = 32,
    parameter logic [DataWidth-1:0] WordZeroVal = '0,
    parameter int unsigned          NumRead     = 3,
    parameter int unsigned          NumWrite    = 2,
    parameter bit                   Bypass      = 1'b0
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          test_en_i,
    input  logic [NumRead*5-1:0]          raddr_i,
    output logic [NumRead*DataWidth-1:0]  rdata_o,
    output logic [NumRead-1:0]            rpend_o,
    input  logic [NumWrite*5-1:0]         waddr_i,
    input  logic [NumWrite*DataWidth-1:0] wdata_i,
    input  logic [NumWrite-1:0]           we_i,
    input  logic                          issue_valid_i,
    input  logic [4:0]                    issue_addr_i,
    output logic                          issue_ready_o,
    output logic                          wr_conflict_o,
    output logic                          addr_err_o
);

    localparam int NumWords = RV32E ? 16 : 32;
    localparam int AddrW    = RV32E ? 4 : 5;
    localparam int NW       = int'(NumWrite);
    localparam int NR       = int'(NumRead);
    localparam int DW       = int'(DataWidth);

    logic [DataWidth-1:0] rf_q [1:NumWords-1];
    logic [NumWords-1:1]  pending_q;
    logic                 conflict_q;
    logic                 addr_err_q;

    logic [NumWords-1:0]  pend_all;
    logic [DataWidth-1:0] rd_all [NumWords];
    logic [NumWrite-1:0]  wvalid;
    logic [AddrW-1:0]     widx [NumWrite];
    logic [NumWords-1:1]  we_dec;
    logic [DataWidth-1:0] wdata_dec [1:NumWords-1];
    logic [NumWords-1:1]  set_d;
    logic                 conflict_d;
    logic                 addr_err_d;
    logic                 issue_ok;
    logic [AddrW-1:0]     issue_idx;
    logic                 issue_fire;

    logic unused_test_en;
    assign unused_test_en = test_en_i;

    function automatic logic in_range(input logic [4:0] a);
        return !RV32E || !a[4];
    endfunction

    always_comb begin
        for (int p = 0; p < NW; p++) begin
            widx[p]   = waddr_i[p*5 +: AddrW];
            wvalid[p] = we_i[p]
                     && in_range(waddr_i[p*5 +: 5])
                     && (widx[p] != '0);
        end
    end

    // Walk ports from highest to lowest so the lowest index wins.
    always_comb begin
        we_dec = '0;
        for (int i = 1; i < NumWords; i++) begin
            wdata_dec[i] = '0;
            for (int p = NW - 1; p >= 0; p--) begin
                if (wvalid[p] && (widx[p] == AddrW'(i))) begin
                    we_dec[i]    = 1'b1;
                    wdata_dec[i] = wdata_i[p*DW +: DW];
                end
            end
        end
    end

    always_comb begin
        conflict_d = 1'b0;
        for (int p = 0; p < NW; p++) begin
            for (int q = p + 1; q < NW; q++) begin
                if (wvalid[p] && wvalid[q] && (widx[p] == widx[q])) begin
                    conflict_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        addr_err_d = 1'b0;
        if (RV32E) begin
            for (int p = 0; p < NW; p++) begin
                if (we_i[p] && waddr_i[p*5+4]) begin
                    addr_err_d = 1'b1;
                end
            end
            if (issue_valid_i && issue_addr_i[4]) begin
                addr_err_d = 1'b1;
            end
        end
    end

    assign pend_all      = {pending_q, 1'b0};
    assign issue_idx     = issue_addr_i[AddrW-1:0];
    assign issue_ok      = in_range(issue_addr_i);
    assign issue_ready_o = !(issue_ok && pend_all[issue_idx]);
    assign issue_fire    = issue_valid_i && issue_ready_o
                        && issue_ok && (issue_idx != '0);

    always_comb begin
        set_d = '0;
        for (int i = 1; i < NumWords; i++) begin
            set_d[i] = issue_fire && (issue_idx == AddrW'(i));
        end
    end

    always_comb begin
        rd_all[0] = WordZeroVal;
        for (int i = 1; i < NumWords; i++) begin
            rd_all[i] = (Bypass && we_dec[i]) ? wdata_dec[i] : rf_q[i];
        end
    end

    always_comb begin
        rdata_o = '0;
        rpend_o = '0;
        for (int k = 0; k < NR; k++) begin
            if (in_range(raddr_i[k*5 +: 5])) begin
                rdata_o[k*DW +: DW] = rd_all[raddr_i[k*5 +: AddrW]];
                rpend_o[k]          = pend_all[raddr_i[k*5 +: AddrW]];
            end else begin
                rdata_o[k*DW +: DW] = WordZeroVal;
                rpend_o[k]          = 1'b0;
            end
        end
    end

    // A new producer issuing in the same cycle as a write keeps ownership.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 1; i < NumWords; i++) begin
                rf_q[i] <= WordZeroVal;
            end
            pending_q  <= '0;
            conflict_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            for (int i = 1; i < NumWords; i++) begin
                if (we_dec[i]) begin
                    rf_q[i] <= wdata_dec[i];
                end
            end
            pending_q  <= set_d | (pending_q & ~we_dec);
            conflict_q <= conflict_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign wr_conflict_o = conflict_q;
    assign addr_err_o    = addr_err_q;

endmodule

// File: tb/tb_cve2_register_file_mp.sv
// Scoreboard bench for cve2_register_file_mp: default, bypass and RV32E
// instances share stimulus; expectations are queued per cycle.
module tb_cve2_register_file_mp;

    localparam int D_RD0  = 0;
    localparam int D_RD1  = 1;
    localparam int D_RD2  = 2;
    localparam int D_PEND = 3;
    localparam int D_RDY  = 4;
    localparam int D_CONF = 5;
    localparam int D_AERR = 6;
    localparam int B_RD0  = 7;
    localparam int B_RD1  = 8;
    localparam int B_RD2  = 9;
    localparam int E_RD0  = 10;
    localparam int E_RD1  = 11;
    localparam int E_PEND = 12;
    localparam int E_RDY  = 13;
    localparam int E_AERR = 14;
    localparam int E_CONF = 15;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [14:0] raddr;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [1:0]  we;
    logic        iv;
    logic [4:0]  ia;

    logic [95:0] d_rdata, b_rdata, e_rdata;
    logic [2:0]  d_rpend, b_rpend, e_rpend;
    logic        d_rdy, b_rdy, e_rdy;
    logic        d_conf, b_conf, e_conf;
    logic        d_aerr, b_aerr, e_aerr;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] mon_act;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    cve2_register_file_mp u_dut (
        .clk_i(clk), .rst_ni(rst_n), .test_en_i(1'b0),
        .raddr_i(raddr), .rdata_o(d_rdata), .rpend_o(d_rpend),
        .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
        .issue_valid_i(iv), .issue_addr_i(ia), .issue_ready_o(d_rdy),
        .wr_conflict_o(d_conf), .addr_err_o(d_aerr)
    );

    cve2_register_file_mp #(.Bypass(1'b1)) u_byp (
        .clk_i(clk), .rst_ni(rst_n), .test_en_i(1'b0),
        .raddr_i(raddr), .rdata_o(b_rdata), .rpend_o(b_rpend),
        .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
        .issue_valid_i(iv), .issue_addr_i(ia), .issue_ready_o(b_rdy),
        .wr_conflict_o(b_conf), .addr_err_o(b_aerr)
    );

    cve2_register_file_mp #(.RV32E(1'b1)) u_e (
        .clk_i(clk), .rst_ni(rst_n), .test_en_i(1'b0),
        .raddr_i(raddr), .rdata_o(e_rdata), .rpend_o(e_rpend),
        .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
        .issue_valid_i(iv), .issue_addr_i(ia), .issue_ready_o(e_rdy),
        .wr_conflict_o(e_conf), .addr_err_o(e_aerr)
    );

    function automatic logic [31:0] actual(input int s);
        case (s)
            D_RD0:   return d_rdata[31:0];
            D_RD1:   return d_rdata[63:32];
            D_RD2:   return d_rdata[95:64];
            D_PEND:  return {29'd0, d_rpend};
            D_RDY:   return {31'd0, d_rdy};
            D_CONF:  return {31'd0, d_conf};
            D_AERR:  return {31'd0, d_aerr};
            B_RD0:   return b_rdata[31:0];
            B_RD1:   return b_rdata[63:32];
            B_RD2:   return b_rdata[95:64];
            E_RD0:   return e_rdata[31:0];
            E_RD1:   return e_rdata[63:32];
            E_PEND:  return {29'd0, e_rpend};
            E_RDY:   return {31'd0, e_rdy};
            E_AERR:  return {31'd0, e_aerr};
            default: return {31'd0, e_conf};
        endcase
    endfunction

    function automatic string sname(input int s);
        case (s)
            D_RD0:   return "rdata0";
            D_RD1:   return "rdata1";
            D_RD2:   return "rdata2";
            D_PEND:  return "rpend";
            D_RDY:   return "issue_ready";
            D_CONF:  return "wr_conflict";
            D_AERR:  return "addr_err";
            B_RD0:   return "byp_rdata0";
            B_RD1:   return "byp_rdata1";
            B_RD2:   return "byp_rdata2";
            E_RD0:   return "e_rdata0";
            E_RD1:   return "e_rdata1";
            E_PEND:  return "e_rpend";
            E_RDY:   return "e_issue_ready";
            E_AERR:  return "e_addr_err";
            default: return "e_wr_conflict";
        endcase
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e   = sb.pop_front();
            mon_act = actual(mon_e.sel);
            n_checks++;
            if (mon_e.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s cycle %0d: expectation never sampled (now %0d)",
                         sname(mon_e.sel), mon_e.cyc, cyc);
            end else if (mon_act !== mon_e.val) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got %h expected %h",
                         sname(mon_e.sel), cyc, mon_act, mon_e.val);
            end
        end
    end

    task automatic expect_val(input int s, input logic [31:0] v);
        exp_t e;
        e.cyc = cyc;
        e.sel = s;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 2'b00;
        iv = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1,
                      input logic [4:0] a2);
        raddr = {a2, a1, a0};
    endtask

    task automatic wr(input logic [1:0] en,
                      input logic [4:0] a0, input logic [31:0] d0,
                      input logic [4:0] a1, input logic [31:0] d1);
        we    = en;
        waddr = {a1, a0};
        wdata = {d1, d0};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        raddr = '0;
        waddr = '0;
        wdata = '0;
        we    = '0;
        iv    = 1'b0;
        ia    = '0;
        step();
        step();
        rst_n = 1'b1;
        // reset test: write x5, issue x7
        wr(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0);
        iv = 1'b1; ia = 5'd7;
        rd(5, 5, 5);
        expect_val(D_RD0, 32'h0);
        expect_val(B_RD0, 32'hDEADBEEF);
        expect_val(D_RDY, 32'd1);
        expect_val(D_PEND, 32'd0);
        step();
        idle();
        rd(5, 7, 7);
        expect_val(D_RD0, 32'hDEADBEEF);
        expect_val(D_PEND, 32'b110);
        expect_val(D_RDY, 32'd0);
        expect_val(E_RD0, 32'hDEADBEEF);
        expect_val(E_PEND, 32'b110);
        step();
        rst_n = 1'b0;
        wr(2'b01, 5'd5, 32'h1, 5'd0, 32'h0);
        iv = 1'b1; ia = 5'd9;
        step();
        rst_n = 1'b1;
        idle();
        ia = 5'd7;
        rd(5, 7, 9);
        expect_val(D_RD0, 32'h0);
        expect_val(D_PEND, 32'd0);
        expect_val(D_RDY, 32'd1);
        expect_val(D_CONF, 32'd0);
        expect_val(D_AERR, 32'd0);
        expect_val(B_RD0, 32'h0);
        expect_val(E_PEND, 32'd0);
        step();
        // write conflict on x3
        wr(2'b11, 5'd3, 32'h11111111, 5'd3, 32'h22222222);
        rd(3, 3, 3);
        expect_val(D_CONF, 32'd0);
        expect_val(D_RD0, 32'h0);
        expect_val(B_RD0, 32'h11111111);
        expect_val(B_RD1, 32'h11111111);
        step();
        idle();
        expect_val(D_RD0, 32'h11111111);
        expect_val(D_RD2, 32'h11111111);
        expect_val(D_CONF, 32'd1);
        expect_val(E_CONF, 32'd1);
        step();
        wr(2'b11, 5'd0, 32'hFFFFFFFF, 5'd0, 32'hFFFFFFFF);
        rd(0, 0, 0);
        expect_val(D_CONF, 32'd0);
        expect_val(E_CONF, 32'd0);
        expect_val(D_RD0, 32'h0);
        expect_val(B_RD0, 32'h0);
        step();
        idle();
        expect_val(D_CONF, 32'd0);
        expect_val(D_RD0, 32'h0);
        step();
        // bypass on x9
        wr(2'b01, 5'd9, 32'hA5A5A5A5, 5'd0, 32'h0);
        rd(9, 9, 9);
        expect_val(B_RD0, 32'hA5A5A5A5);
        expect_val(B_RD1, 32'hA5A5A5A5);
        expect_val(B_RD2, 32'hA5A5A5A5);
        expect_val(D_RD0, 32'h0);
        expect_val(D_RD1, 32'h0);
        step();
        idle();
        expect_val(D_RD0, 32'hA5A5A5A5);
        expect_val(D_RD1, 32'hA5A5A5A5);
        expect_val(D_RD2, 32'hA5A5A5A5);
        expect_val(D_PEND, 32'd0);
        step();
        wr(2'b11, 5'd9, 32'h1, 5'd9, 32'h2);
        expect_val(B_RD0, 32'h1);
        expect_val(D_RD0, 32'hA5A5A5A5);
        step();
        idle();
        expect_val(D_RD0, 32'h1);
        expect_val(D_CONF, 32'd1);
        step();
        // scoreboard on x4
        iv = 1'b1; ia = 5'd4;
        rd(4, 4, 4);
        expect_val(D_RDY, 32'd1);
        expect_val(D_PEND, 32'd0);
        step();
        expect_val(D_RDY, 32'd0);
        expect_val(D_PEND, 32'b111);
        step();
        iv = 1'b0;
        wr(2'b01, 5'd4, 32'h44, 5'd0, 32'h0);
        expect_val(D_PEND, 32'b111);
        expect_val(D_RDY, 32'd0);
        step();
        iv = 1'b1;
        wr(2'b01, 5'd4, 32'h55, 5'd0, 32'h0);
        expect_val(D_PEND, 32'd0);
        expect_val(D_RDY, 32'd1);
        expect_val(D_RD0, 32'h44);
        step();
        iv = 1'b0;
        wr(2'b01, 5'd4, 32'h66, 5'd0, 32'h0);
        expect_val(D_PEND, 32'b111);
        expect_val(D_RDY, 32'd0);
        expect_val(D_RD0, 32'h55);
        step();
        idle();
        expect_val(D_PEND, 32'd0);
        expect_val(D_RDY, 32'd1);
        expect_val(D_RD0, 32'h66);
        expect_val(E_RD0, 32'h66);
        step();
        // x0 write and issue
        wr(2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0);
        iv = 1'b1; ia = 5'd0;
        rd(0, 0, 0);
        expect_val(D_RDY, 32'd1);
        expect_val(D_RD0, 32'h0);
        expect_val(B_RD0, 32'h0);
        expect_val(D_PEND, 32'd0);
        step();
        idle();
        rd(0, 4, 9);
        expect_val(D_RD0, 32'h0);
        expect_val(D_RDY, 32'd1);
        expect_val(D_PEND, 32'd0);
        step();
        // out-of-range accesses on the RV32E instance
        wr(2'b01, 5'd20, 32'h1234, 5'd0, 32'h0);
        iv = 1'b1; ia = 5'd18;
        rd(20, 4, 2);
        expect_val(E_RD0, 32'h0);
        expect_val(E_RD1, 32'h66);
        expect_val(E_AERR, 32'd0);
        expect_val(D_AERR, 32'd0);
        expect_val(D_RD0, 32'h0);
        step();
        idle();
        ia = 5'd2;
        expect_val(E_AERR, 32'd1);
        expect_val(E_RD0, 32'h0);
        expect_val(E_RD1, 32'h66);
        expect_val(E_PEND, 32'd0);
        expect_val(E_RDY, 32'd1);
        expect_val(D_AERR, 32'd0);
        expect_val(D_RD0, 32'h1234);
        step();
        expect_val(E_AERR, 32'd0);
        step();
        step();
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s cycle %0d: expectation left unchecked",
                     sname(mon_e.sel), mon_e.cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cve2_register_file_mp.md
# cve2_register_file_mp

Parametrised multi-port flip-flop register file with an integrated write-pending scoreboard. It provides `NumRead` read ports and `NumWrite` write ports, configurable RV32E depth, optional write-to-read bypass and fixed-priority write arbitration. It adds per-register pending tracking with an issue handshake, so a multi-issue cve2 pipeline can stall on RAW hazards. It replaces the fixed 3-read/2-write register file in the decode/writeback path; x0 is hard-wired to `WordZeroVal`.

## Interface
- `RV32E`, 0: 1 gives 16 registers (x0–x15); 0 gives 32.
- `DataWidth`, 32: register width in bits.
- `WordZeroVal`, '0: reset value of every register and the constant value of x0.
- `NumRead`, 3: number of read ports, 1–4.
- `NumWrite`, 2: number of write ports, 1–3.
- `Bypass`, 0: 1 forwards same-cycle write data to the read ports.
- `clk_i`  in  1  clock, rising edge.
- `rst_ni`  in  1  synchronous, active-low reset.
- `test_en_i`  in  1  unused; kept for interface compatibility.
- `raddr_i`  in  NumRead*5  read address; port k uses bits [5k+4:5k].
- `rdata_o`  out  NumRead*DataWidth  read data, combinational.
- `rpend_o`  out  NumRead  pending bit of the addressed register, combinational.
- `waddr_i`  in  NumWrite*5  write address per port.
- `wdata_i`  in  NumWrite*DataWidth  write data per port.
- `we_i`  in  NumWrite  write enable per port.
- `issue_valid_i`  in  1  a producer instruction targets `issue_addr_i`.
- `issue_addr_i`  in  5  destination register of the issuing instruction.
- `issue_ready_o`  out  1  issue accepted in this cycle.
- `wr_conflict_o`  out  1  registered pulse: two enabled write ports targeted the same nonzero register in the previous cycle.
- `addr_err_o`  out  1  registered pulse: with RV32E=1, an enabled write or an issue used an address ≥ 16 in the previous cycle.

## Operation
- **Storage:** registers 1..NUM_WORDS-1 are flops. x0 has no flop and reads `WordZeroVal`. NUM_WORDS is 16 when RV32E=1, else 32.
- **Write arbitration:** when several enabled ports target the same register, the lowest-index port wins. Writes to x0 are dropped.
- **RV32E address checking:**
  - Writes and issues with address bit 4 set are ignored and raise `addr_err_o`.
  - Reads with bit 4 set return `WordZeroVal`, and `rpend_o` returns 0.
- **Read path:**
  - `Bypass`=0: `rdata_o` returns the flop value.
  - `Bypass`=1: if an enabled write port targets the read address (nonzero, in range), `rdata_o` returns the winning port's `wdata_i`.
- **Scoreboard:** one `pending[i]` bit per register, i ≥ 1.
  - Issue handshake fires when `issue_valid_i` && `issue_ready_o`.
  - `issue_ready_o` = !pending[issue_addr_i]. Its value is independent of `issue_valid_i`; for x0 it is always 1.
  - Handshake to nonzero i sets pending[i] at the next edge. Handshake to x0 changes nothing.
  - Any enabled write to register i clears pending[i] at the next edge.
  - Same-cycle handshake and write to the same i: the set wins, pending[i] stays 1 (the new producer owns the register).
  - A write to a register that is not pending is legal and leaves pending at 0.
- **`wr_conflict_o`:** asserted for one cycle after any cycle in which ≥2 enabled ports addressed the same nonzero, in-range register.

## Timing
- Write latency is 1 cycle: data is visible on `rdata_o` in the cycle after `we_i` (or in the same cycle when `Bypass`=1).
- Pending latency: a bit set by a handshake at edge N is visible on `rpend_o`/`issue_ready_o` from cycle N+1; a clear follows the same rule.
- `issue_ready_o`, `rdata_o` and `rpend_o` are purely combinational from addresses and state. There is no path from `issue_valid_i` to `issue_ready_o`.
- **Reset** (`rst_ni`=0 at a rising edge), taking priority over all writes and issues in that cycle:
  - every register takes `WordZeroVal`;
  - every pending bit clears;
  - `wr_conflict_o` and `addr_err_o` go to 0.
- Reset mid-operation discards in-flight writes and issues of that cycle. After reset: `issue_ready_o`=1 for every address, `rpend_o`=0.
- An asynchronous reset edge has no effect until the next clock edge.

## Test plan
- **Reset:** write x5=0xDEADBEEF, issue x7, then hold `rst_ni` low for one edge. Require rdata(x5)=WordZeroVal, `rpend_o`=0 for x7, and both pulse outputs at 0.
- **Write conflict:** ports 0 and 1 both write x3, with 0x11111111 and 0x22222222. The next cycle requires x3=0x11111111 and `wr_conflict_o`=1 for exactly one cycle.
- **Bypass:**
  - `Bypass`=1, write x9=0xA5A5A5A5 while reading x9 on all ports: 0xA5A5A5A5 in the same cycle.
  - `Bypass`=0: the old value in that cycle, the new value the next cycle.
- **Scoreboard:** issue x4, then the next cycle issue x4 again. Require `issue_ready_o`=0 and `rpend_o`=1 for x4. Write x4 while also issuing x4 in the same cycle; pending stays 1 afterwards. Write x4 alone; pending clears the next cycle.
- **x0 handling:** write x0=0xFFFFFFFF and issue x0. Require rdata(x0)=WordZeroVal, `issue_ready_o`=1 and no pending change.
- **RV32E=1:** write x20=0x1234 and issue x18. Require `addr_err_o`=1 for one cycle. Reads of x20 and x4 are unchanged, and no pending bit is set.
